// File: rtl/lpc_host_if.sv
// Request/response handshake and LPC pin bundle for the lpc_host initiator.
// master is the initiator side; slave is the requester plus peripheral side.
interface lpc_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cyctype_dir;
  logic [31:0] req_addr;
  logic [7:0]  req_data;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_error;
  logic        resp_sync_timeout;
  logic [3:0]  lpc_ad_in;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic        lpc_frame;

  modport master (
    input  req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
    output req_ready, resp_valid, resp_data, resp_error, resp_sync_timeout,
           lpc_ad_out, lpc_ad_oe, lpc_frame
  );

  modport slave (
    output req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
    input  req_ready, resp_valid, resp_data, resp_error, resp_sync_timeout,
           lpc_ad_out, lpc_ad_oe, lpc_frame
  );
endinterface

// File: rtl/lpc_host.sv
// LPC bus initiator: serialises one I/O or memory request onto LAD and returns
// a one-cycle completion carrying read data and error/timeout status.
//
// state   | meaning
// IDLE    | ready for a request; completion pulse on the first cycle here
// START   | LFRAME# low, LAD 0000
// CYCTYPE | drive cycle type / direction nibble
// ADDR    | drive address nibbles, MSB first (4 for I/O, 8 for memory)
// WDATA   | drive write data, low nibble then high nibble
// TAR_H   | host turnaround: 1111 driven, then released
// SYNC    | wait for peripheral ready/error, bounded by the two timeouts
// RDATA   | sample read data, low nibble then high nibble
// TAR_P   | peripheral turnaround, LAD ignored
// ABORT   | LFRAME# low with LAD 1111 for 4 cycles after a timeout
module lpc_host #(
  parameter int SYNC_TIMEOUT = 8,
  parameter int LONG_TIMEOUT = 1024
) (
  input logic        clock,
  input logic        reset,
  lpc_host_if.master bus
);
  localparam int SW = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam int LW = (LONG_TIMEOUT > 1) ? $clog2(LONG_TIMEOUT) : 1;
  localparam logic [SW-1:0] SHORT_LOAD = SW'(SYNC_TIMEOUT - 1);
  localparam logic [LW-1:0] LONG_LOAD  = LW'(LONG_TIMEOUT - 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] START   = 4'd1;
  localparam logic [3:0] CYCTYPE = 4'd2;
  localparam logic [3:0] ADDR    = 4'd3;
  localparam logic [3:0] WDATA   = 4'd4;
  localparam logic [3:0] TAR_H   = 4'd5;
  localparam logic [3:0] SYNC    = 4'd6;
  localparam logic [3:0] RDATA   = 4'd7;
  localparam logic [3:0] TAR_P   = 4'd8;
  localparam logic [3:0] ABORT   = 4'd9;

  logic [3:0]    state, nxt_state;
  logic [2:0]    idx, nxt_idx;
  logic [SW-1:0] short_cnt, nxt_short;
  logic [LW-1:0] long_cnt, nxt_long;
  logic          err_flag, nxt_err;
  logic [7:0]    rdata, nxt_rdata;
  logic [3:0]    cyc_q;
  logic [31:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          accept, bad_type, is_mem, is_write;
  logic          done, done_err, done_to;
  logic [7:0]    done_data;
  logic          nxt_frame, nxt_oe;
  logic [3:0]    nxt_ad;

  assign accept   = (state == IDLE) && bus.req_ready && bus.req_valid;
  assign bad_type = (bus.req_cyctype_dir[3:2] > 2'b01) || bus.req_cyctype_dir[0];
  assign is_mem   = cyc_q[2];
  assign is_write = cyc_q[1];

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_short = short_cnt;
    nxt_long  = long_cnt;
    nxt_err   = err_flag;
    nxt_rdata = rdata;
    done      = 1'b0;
    done_err  = 1'b0;
    done_to   = 1'b0;
    done_data = 8'h00;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_type) begin
            done     = 1'b1;
            done_err = 1'b1;
          end else begin
            nxt_state = START;
          end
        end
      end
      START: begin
        nxt_state = CYCTYPE;
        nxt_err   = 1'b0;
        nxt_rdata = 8'h00;
      end
      CYCTYPE: begin
        nxt_state = ADDR;
        nxt_idx   = is_mem ? 3'd7 : 3'd3;
      end
      ADDR: begin
        if (idx == 3'd0) nxt_state = is_write ? WDATA : TAR_H;
        else             nxt_idx   = idx - 3'd1;
      end
      WDATA: begin
        if (idx == 3'd1) begin
          nxt_state = TAR_H;
          nxt_idx   = 3'd0;
        end else begin
          nxt_idx = 3'd1;
        end
      end
      TAR_H: begin
        if (idx == 3'd1) begin
          nxt_state = SYNC;
          nxt_short = SHORT_LOAD;
          nxt_long  = LONG_LOAD;
        end else begin
          nxt_idx = 3'd1;
        end
      end
      SYNC: begin
        case (bus.lpc_ad_in)
          4'b0000, 4'b1010: begin
            nxt_err   = err_flag | bus.lpc_ad_in[3];
            nxt_idx   = 3'd0;
            nxt_state = is_write ? TAR_P : RDATA;
          end
          4'b0110: begin
            nxt_short = SHORT_LOAD;
            if (long_cnt == '0) begin
              nxt_state = ABORT;
              nxt_idx   = 3'd0;
            end else begin
              nxt_long = long_cnt - LW'(1);
            end
          end
          default: begin
            nxt_long = LONG_LOAD;
            if (short_cnt == '0) begin
              nxt_state = ABORT;
              nxt_idx   = 3'd0;
            end else begin
              nxt_short = short_cnt - SW'(1);
            end
          end
        endcase
      end
      RDATA: begin
        if (idx == 3'd0) begin
          nxt_rdata[3:0] = bus.lpc_ad_in;
          nxt_idx        = 3'd1;
        end else begin
          nxt_rdata[7:4] = bus.lpc_ad_in;
          nxt_idx        = 3'd0;
          nxt_state      = TAR_P;
        end
      end
      TAR_P: begin
        if (idx == 3'd1) begin
          nxt_state = IDLE;
          done      = 1'b1;
          done_err  = err_flag;
          done_data = rdata;
        end else begin
          nxt_idx = 3'd1;
        end
      end
      ABORT: begin
        if (idx == 3'd3) begin
          nxt_state = IDLE;
          done      = 1'b1;
          done_to   = 1'b1;
        end else begin
          nxt_idx = idx + 3'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they leave a flop.
  always_comb begin
    nxt_frame = 1'b1;
    nxt_oe    = 1'b0;
    nxt_ad    = 4'hF;
    case (nxt_state)
      START: begin
        nxt_frame = 1'b0;
        nxt_oe    = 1'b1;
        nxt_ad    = 4'h0;
      end
      CYCTYPE: begin
        nxt_oe = 1'b1;
        nxt_ad = cyc_q;
      end
      ADDR: begin
        nxt_oe = 1'b1;
        nxt_ad = addr_q[{nxt_idx, 2'b00} +: 4];
      end
      WDATA: begin
        nxt_oe = 1'b1;
        nxt_ad = nxt_idx[0] ? wdata_q[7:4] : wdata_q[3:0];
      end
      TAR_H:   nxt_oe = ~nxt_idx[0];
      ABORT: begin
        nxt_frame = 1'b0;
        nxt_oe    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      idx                   <= 3'd0;
      short_cnt             <= SHORT_LOAD;
      long_cnt              <= LONG_LOAD;
      err_flag              <= 1'b0;
      rdata                 <= 8'h00;
      cyc_q                 <= 4'h0;
      addr_q                <= 32'h0;
      wdata_q               <= 8'h00;
      bus.req_ready         <= 1'b0;
      bus.resp_valid        <= 1'b0;
      bus.resp_data         <= 8'h00;
      bus.resp_error        <= 1'b0;
      bus.resp_sync_timeout <= 1'b0;
      bus.lpc_frame         <= 1'b1;
      bus.lpc_ad_oe         <= 1'b0;
      bus.lpc_ad_out        <= 4'hF;
    end else begin
      state     <= nxt_state;
      idx       <= nxt_idx;
      short_cnt <= nxt_short;
      long_cnt  <= nxt_long;
      err_flag  <= nxt_err;
      rdata     <= nxt_rdata;
      if (accept) begin
        cyc_q   <= bus.req_cyctype_dir;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_data;
      end
      bus.req_ready  <= (nxt_state == IDLE);
      bus.resp_valid <= done;
      if (done) begin
        bus.resp_data         <= done_data;
        bus.resp_error        <= done_err;
        bus.resp_sync_timeout <= done_to;
      end
      bus.lpc_frame  <= nxt_frame;
      bus.lpc_ad_oe  <= nxt_oe;
      bus.lpc_ad_out <= nxt_ad;
    end
  end
endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: a driver plays requester and peripheral while
// two monitors score driven LAD nibbles and completion responses from queues.
module tb_lpc_host;
  typedef struct {
    logic [3:0]  cyc;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [63:0] sync;
    int          n_sync;
    logic [3:0]  stuck;
    logic [7:0]  rdata;
    int          lat;
    logic [7:0]  e_data;
    logic        e_err;
    logic        e_to;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
    logic       to;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic mon_en = 1'b0;

  logic [4:0] bus_q[$];
  resp_t      resp_q[$];
  vec_t       vecs[14];

  lpc_host_if bus();

  lpc_host #(.SYNC_TIMEOUT(8), .LONG_TIMEOUT(1024)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [7:0] wd,
                              input logic [63:0] s, input int n, input logic [3:0] st,
                              input logic [7:0] rd, input int lat, input logic [7:0] ed,
                              input logic ee, input logic et);
    vec_t v;
    v.cyc = c; v.addr = a; v.wdata = wd; v.sync = s; v.n_sync = n; v.stuck = st;
    v.rdata = rd; v.lat = lat; v.e_data = ed; v.e_err = ee; v.e_to = et;
    return v;
  endfunction

  // LAD monitor: every driven cycle must match the next expected {frame, nibble}.
  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.lpc_ad_oe === 1'b1) begin
        if (bus_q.size() == 0) chk("lad_unexpected_drive", {bus.lpc_frame, bus.lpc_ad_out}, 5'h1F);
        else chk("lad_drive", {bus.lpc_frame, bus.lpc_ad_out}, bus_q.pop_front());
      end else begin
        chk("frame_idle", bus.lpc_frame, 1'b1);
      end
    end
  end

  // Response monitor.
  always @(negedge clock) begin
    resp_t r;
    if (mon_en && bus.resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", 1'b1, 1'b0);
      end else begin
        r = resp_q.pop_front();
        chk("resp_cycle", cyc, r.cyc);
        chk("resp_data", bus.resp_data, r.data);
        chk("resp_error", bus.resp_error, r.err);
        chk("resp_timeout", bus.resp_sync_timeout, r.to);
      end
    end
  end

  task automatic run(input vec_t v);
    int    acc, k, s0, j;
    logic  sup, mem, wr;
    resp_t r;
    sup = (v.cyc[3:2] <= 2'b01) && !v.cyc[0];
    mem = v.cyc[2];
    wr  = v.cyc[1];
    if (sup) begin
      bus_q.push_back({1'b0, 4'h0});
      bus_q.push_back({1'b1, v.cyc});
      for (int i = (mem ? 7 : 3); i >= 0; i--) bus_q.push_back({1'b1, v.addr[4*i +: 4]});
      if (wr) begin
        bus_q.push_back({1'b1, v.wdata[3:0]});
        bus_q.push_back({1'b1, v.wdata[7:4]});
      end
      bus_q.push_back({1'b1, 4'hF});
      if (v.e_to) repeat (4) bus_q.push_back({1'b0, 4'hF});
    end
    @(negedge clock);
    bus.req_valid       = 1'b1;
    bus.req_cyctype_dir = v.cyc;
    bus.req_addr        = v.addr;
    bus.req_data        = v.wdata;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("req_ready", bus.req_ready, 1'b1);
    acc = cyc + 1;
    r.cyc = acc + v.lat - 1; r.data = v.e_data; r.err = v.e_err; r.to = v.e_to;
    resp_q.push_back(r);
    s0 = (wr ? 11 : 9) + (mem ? 4 : 0);
    for (int rel = 1; rel <= v.lat + 1; rel++) begin
      @(negedge clock);
      if (rel == 1) begin
        bus.req_valid       = 1'b0;
        bus.req_cyctype_dir = 4'hE;
        bus.req_addr        = 32'hDEAD_BEEF;
        bus.req_data        = 8'hEE;
      end
      j = rel - s0;
      if (j < 0)                          bus.lpc_ad_in = 4'hF;
      else if (v.n_sync == 0)             bus.lpc_ad_in = v.stuck;
      else if (j < v.n_sync)              bus.lpc_ad_in = v.sync[4*(v.n_sync-1-j) +: 4];
      else if (!wr && j == v.n_sync)      bus.lpc_ad_in = v.rdata[3:0];
      else if (!wr && j == v.n_sync + 1)  bus.lpc_ad_in = v.rdata[7:4];
      else                                bus.lpc_ad_in = 4'hC;
    end
    bus.lpc_ad_in = 4'hF;
    chk("resp_pending", resp_q.size(), 0);
    if (resp_q.size() != 0) resp_q.delete();
    chk("resp_hold", {bus.resp_valid, bus.resp_data, bus.resp_error, bus.resp_sync_timeout},
        {1'b0, v.e_data, v.e_err, v.e_to});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             cyc    addr           wdata  sync                 n   stuck rdata lat   data   err   to
    vecs[0]  = mk(4'h2, 32'h0000_0080, 8'h34, 64'h50,               2,  4'h0, 8'h00, 15,   8'h00, 1'b0, 1'b0);
    vecs[1]  = mk(4'h0, 32'h0000_03F9, 8'h00, 64'h0,                1,  4'h0, 8'h5A, 14,   8'h5A, 1'b0, 1'b0);
    vecs[2]  = mk(4'h4, 32'hFFFF_FFF0, 8'h00, 64'hA,                1,  4'h0, 8'h12, 18,   8'h12, 1'b1, 1'b0);
    vecs[3]  = mk(4'h0, 32'h0000_0060, 8'h00, 64'h0,                0,  4'hF, 8'h00, 21,   8'h00, 1'b0, 1'b1);
    vecs[4]  = mk(4'h2, 32'h0000_0061, 8'hA5, 64'h0,                1,  4'h0, 8'h00, 14,   8'h00, 1'b0, 1'b0);
    vecs[5]  = mk(4'h6, 32'h1234_5678, 8'h9C, 64'h6650,             4,  4'h0, 8'h00, 21,   8'h00, 1'b0, 1'b0);
    vecs[6]  = mk(4'h4, 32'h000C_0000, 8'h00, 64'h5550,             4,  4'h0, 8'hE7, 21,   8'hE7, 1'b0, 1'b0);
    vecs[7]  = mk(4'h8, 32'h0000_0010, 8'h00, 64'h0,                1,  4'h0, 8'h00, 1,    8'h00, 1'b1, 1'b0);
    vecs[8]  = mk(4'h1, 32'h0000_0010, 8'h00, 64'h0,                1,  4'h0, 8'h00, 1,    8'h00, 1'b1, 1'b0);
    vecs[9]  = mk(4'h2, 32'h0000_0001, 8'hFF, 64'h5555_5550,        8,  4'h0, 8'h00, 21,   8'h00, 1'b0, 1'b0);
    vecs[10] = mk(4'h0, 32'h0000_0002, 8'h00, 64'h5555_5655_5550,   12, 4'h0, 8'h3C, 25,   8'h3C, 1'b0, 1'b0);
    vecs[11] = mk(4'h4, 32'h0000_0000, 8'h00, 64'h0,                0,  4'h6, 8'h00, 1041, 8'h00, 1'b0, 1'b1);
    vecs[12] = mk(4'h2, 32'h0000_0070, 8'h55, 64'h0,                0,  4'h5, 8'h00, 23,   8'h00, 1'b0, 1'b1);
    vecs[13] = mk(4'h0, 32'h0000_03F9, 8'h00, 64'hA,                1,  4'h0, 8'h81, 14,   8'h81, 1'b1, 1'b0);

    bus.req_valid       = 1'b0;
    bus.req_cyctype_dir = 4'h0;
    bus.req_addr        = 32'h0;
    bus.req_data        = 8'h00;
    bus.lpc_ad_in       = 4'hF;

    repeat (3) @(negedge clock);
    chk("rst_frame", bus.lpc_frame, 1'b1);
    chk("rst_oe", bus.lpc_ad_oe, 1'b0);
    chk("rst_ad", bus.lpc_ad_out, 4'hF);
    chk("rst_resp", {bus.resp_valid, bus.resp_data, bus.resp_error, bus.resp_sync_timeout}, 11'h0);
    chk("rst_ready", bus.req_ready, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_release_ready", bus.req_ready, 1'b1);
    mon_en = 1'b1;

    for (int i = 0; i < 13; i++) run(vecs[i]);

    // Reset during ADDR of an I/O write to 0x0042: only four nibbles get out.
    bus_q.push_back({1'b0, 4'h0});
    bus_q.push_back({1'b1, 4'h2});
    bus_q.push_back({1'b1, 4'h0});
    bus_q.push_back({1'b1, 4'h0});
    @(negedge clock);
    bus.req_valid       = 1'b1;
    bus.req_cyctype_dir = 4'h2;
    bus.req_addr        = 32'h0000_0042;
    bus.req_data        = 8'h11;
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_frame", bus.lpc_frame, 1'b1);
    chk("midrst_oe", bus.lpc_ad_oe, 1'b0);
    chk("midrst_resp_valid", bus.resp_valid, 1'b0);
    chk("midrst_ready", bus.req_ready, 1'b0);
    chk("midrst_resp_clr", {bus.resp_data, bus.resp_error, bus.resp_sync_timeout}, 10'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_release_ready", bus.req_ready, 1'b1);
    chk("midrst_no_resp", bus.resp_valid, 1'b0);

    run(vecs[13]);

    repeat (2) @(negedge clock);
    chk("lad_queue_empty", bus_q.size(), 0);
    chk("resp_queue_empty", resp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
